seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 81 ++++++++
 tb/tb_seq_multiplier.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier for the EX stage: one partial product per cycle,
// fixed WIDTH-cycle latency, stall via busy_o and a one-cycle done_o pulse.
module seq_multiplier #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = 4'b1111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_step;
  logic             start, last;

  // rst_i gates start so busy_o is held low for the whole reset window
  always_comb begin
    start    = rst_i & valid_i & (ALUCtrl_i == MUL_CODE) & ~flush_i &
               ((state == IDLE) | (state == DONE));
    acc_step = mplier[0] ? acc + mcand : acc;
    last     = (cnt == CW'(1));
  end

  always_comb begin
    state_nxt = state;
    done_o    = 1'b0;
    busy_o    = start;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy_o = 1'b1;
        if (flush_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mcand  <= src1_i;
        mplier <= src2_i;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == RUN && !flush_i) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        // final step's partial sum goes straight into the result on DONE entry
        if (last) result_o <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier; expected products come from
// plain 32-bit multiplication and a fixed 33-cycle accept-to-done timeline.
module tb_seq_multiplier;

  localparam logic [3:0] MUL = 4'b1111;

  logic        clk, rst_n, valid, flush;
  logic [3:0]  alu;
  logic [31:0] src1, src2, result;
  logic        done, busy;

  int          n_cmp, n_bad;
  logic [31:0] exp_result;

  seq_multiplier #(.WIDTH(32), .MUL_CODE(MUL)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUCtrl_i(alu),
    .src1_i(src1), .src2_i(src2), .flush_i(flush),
    .result_o(result), .done_o(done), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a multiply in the current cycle and follows it to its done pulse.
  // Operands/controls are scrambled during RUN to prove they are ignored.
  // With flush_done set, the DONE cycle also carries flush + a mul request.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input bit flush_done, input string tag);
    logic [31:0] exp;
    int bad_run;
    exp = a * b;
    valid = 1'b1; alu = MUL; src1 = a; src2 = b; flush = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s accept busy: got %b want 1", tag, busy);
    end
    tick;
    bad_run = 0;
    for (int k = 1; k <= 32; k++) begin
      valid = 1'($urandom); alu = 4'($urandom); src1 = $urandom; src2 = $urandom;
      #1;
      if (busy !== 1'b1 || done !== 1'b0) bad_run++;
      tick;
    end
    valid = flush_done; alu = MUL; flush = flush_done;
    #1;
    n_cmp++;
    if (bad_run != 0) begin
      n_bad++; $display("FAIL %s run window: %0d bad cycles want 0", tag, bad_run);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done cycle: done=%b busy=%b want done=1 busy=0", tag, done, busy);
    end
    n_cmp++;
    if (result !== exp) begin
      n_bad++; $display("FAIL %s result: got %h want %h", tag, result, exp);
    end
    exp_result = exp;
    tick;
    valid = 1'b0; flush = 1'b0; alu = 4'd0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_result) begin
      n_bad++;
      $display("FAIL %s after done: done=%b busy=%b result=%h want 0 0 %h",
               tag, done, busy, result, exp_result);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b1; alu = MUL; src1 = $urandom; src2 = $urandom; flush = 1'b0;
    #3;
    n_cmp++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset outputs: result=%h done=%b busy=%b want 0", result, done, busy);
    end
    tick; tick;
    n_cmp++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset held: result=%h done=%b busy=%b want 0", result, done, busy);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    exp_result = 32'd0;
    // start presented before the very first edge with reset released
    do_mul(32'd3, 32'd5, 1'b0, "first_start");
  endtask

  task automatic test_corners;
    do_mul(32'hFFFF_FFFE, 32'd7,        1'b0, "neg_trunc");
    do_mul(32'h0001_0000, 32'h0001_0000, 1'b0, "overflow");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "all_ones");
    do_mul(32'd0,         32'hDEAD_BEEF, 1'b0, "zero");
    do_mul(32'h8000_0000, 32'd1,        1'b1, "flush_in_done");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) do_mul($urandom, $urandom, 1'b0, "random");
  endtask

  task automatic test_flush;
    int bad;
    logic [31:0] keep;
    keep = exp_result;
    valid = 1'b1; alu = MUL; src1 = 32'd3; src2 = 32'd5;
    tick;
    valid = 1'b0;
    for (int k = 1; k < 10; k++) tick;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL flush cycle busy: got %b want 1", busy);
    end
    tick;
    flush = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL flush aftermath: busy=%b done=%b want 0 0", busy, done);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0 || busy !== 1'b0 || result !== keep) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL flush no_done: %0d bad cycles want 0 (result=%h keep=%h)", bad, result, keep);
    end
    do_mul(32'd12, 32'd13, 1'b0, "after_flush");
  endtask

  task automatic test_reset_mid;
    int bad;
    valid = 1'b1; alu = MUL; src1 = 32'd3; src2 = 32'd5;
    tick;
    for (int k = 1; k < 20; k++) tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid outputs: result=%h done=%b busy=%b want 0", result, done, busy);
    end
    exp_result = 32'd0;
    tick; tick;
    valid = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd0) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL reset_mid release: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_nonmul;
    int bad;
    bad = 0;
    valid = 1'b1; alu = 4'b0010; src1 = $urandom; src2 = $urandom;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      tick;
    end
    for (int k = 0; k < 10; k++) begin
      alu = 4'($urandom_range(0, 14));
      #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL nonmul busy: %0d bad cycles want 0", bad);
    end
    alu = MUL; flush = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_vs_start busy: got %b want 0", busy);
    end
    tick;
    valid = 1'b0; flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || result !== exp_result) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL flush_vs_start idle: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    valid = 1'b1; alu = MUL; src1 = 32'd6; src2 = 32'd7;
    tick;
    valid = 1'b0;
    for (int k = 1; k <= 32; k++) tick;
    valid = 1'b1; alu = MUL; src1 = 32'd9; src2 = 32'd9;
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || result !== 32'd42) begin
      n_bad++; $display("FAIL b2b first: done=%b busy=%b result=%0d want 1 1 42", done, busy, result);
    end
    tick;
    valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      #1;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd42) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL b2b run window: %0d bad cycles want 0", bad);
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd81) begin
      n_bad++; $display("FAIL b2b second: done=%b busy=%b result=%0d want 1 0 81", done, busy, result);
    end
    exp_result = 32'd81;
    tick;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_result = 32'd0;
    rst_n = 1'b0; valid = 1'b0; alu = 4'd0; src1 = 32'd0; src2 = 32'd0; flush = 1'b0;
    #1;
    test_reset;
    test_corners;
    test_random;
    test_flush;
    test_nonmul;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
